qspi_prog_sequencer: RTL and testbench

- Sequences qspi_fsm through a complete flash write-class operation: WREN (0x06), then the program/erase command, then repeated RDSR (0x05) polls until WIP clears or the poll budget runs out.
- Sits between the register/command front end and qspi_fsm.
- Owns start and all per-transaction config ports of qspi_fsm.
- Does not drive clk_div, cpol or cpha; those stay with the register file.

---
 rtl/qspi_seq_pkg.sv | 56 +++++
 rtl/qspi_seq_timer.sv | 39 +++
 rtl/qspi_prog_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_prog_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_seq_pkg.sv
// Shared types and constants for the QSPI program/erase sequencer.
package qspi_seq_pkg;

  localparam int unsigned STATUS_W = 8;
  localparam int unsigned GAP_W    = 8;
  localparam int unsigned POLL_W   = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WREN_ISSUE,
    S_WREN_WAIT,
    S_WEL_ISSUE,
    S_WEL_WAIT,
    S_OP_ISSUE,
    S_OP_WAIT,
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_CE   = 8'hC7;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  typedef enum logic [1:0] {
    REQ_PP   = 2'b00,
    REQ_SE   = 2'b01,
    REQ_CE   = 2'b10,
    REQ_RSVD = 2'b11
  } req_op_e;

  localparam logic [1:0] ABS_NONE = 2'b00;
  localparam logic [1:0] ABS_3B   = 2'b01;
  localparam logic [1:0] ABS_4B   = 2'b10;

  // Per-transaction configuration handed to qspi_fsm.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] addr;
    logic [31:0] len;
    logic [1:0]  addr_sel;
    logic        dir;
  } fsm_cfg_t;

  function automatic logic [7:0] op_opcode(input req_op_e op);
    case (op)
      REQ_PP:  return OPC_PP;
      REQ_SE:  return OPC_SE;
      default: return OPC_CE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_seq_timer.sv
// Loadable down-counter; expired_o is high once the loaded count has run down to its last cycle.
module qspi_seq_timer
  import qspi_seq_pkg::*;
#(
  parameter int unsigned W = GAP_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d <= W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/qspi_prog_sequencer.sv
// Drives qspi_fsm through WREN, program/erase, then RDSR polling until WIP clears.
// Optional WEL verification after WREN is enabled by defining QSPI_SEQ_WEL_CHECK_EN.
module qspi_prog_sequencer
  import qspi_seq_pkg::*;
#(
  parameter logic [15:0] POLL_MAX = 16'd65535,
  parameter logic [7:0]  POLL_GAP = 8'd16,
  parameter logic        ADDR4    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  output logic        seq_done,
  output logic        seq_err,
  output logic        fsm_start,
  input  logic        fsm_done,
  output logic [7:0]  fsm_cmd_opcode,
  output logic [31:0] fsm_addr,
  output logic [31:0] fsm_len_bytes,
  output logic [1:0]  fsm_addr_bytes_sel,
  output logic        fsm_dir,
  output logic [1:0]  fsm_cmd_lanes_sel,
  output logic [1:0]  fsm_addr_lanes_sel,
  output logic [1:0]  fsm_data_lanes_sel,
  output logic        fsm_mode_en,
  output logic [3:0]  fsm_dummy_cycles,
  input  logic [31:0] rx_data,
  input  logic        rx_wen
);

  localparam logic [1:0] ADDR_SEL = ADDR4 ? ABS_4B : ABS_3B;
  localparam fsm_cfg_t   CFG_RDSR = '{opcode: OPC_RDSR, addr: 32'd0, len: 32'd1,
                                      addr_sel: ABS_NONE, dir: 1'b0};

  state_e                state_q, state_d;
  req_op_e               op_q, op_d;
  logic [31:0]           addr_q, addr_d, len_q, len_d;
  fsm_cfg_t              cfg_q, cfg_d;
  logic                  start_q, start_d, ready_q, ready_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [STATUS_W-1:0]   status_q, status_d, status_now;
  logic [POLL_W-1:0]     poll_q, poll_d;
  logic                  gap_load, gap_expired;
  logic                  unused_rx;

  // A byte arriving together with fsm_done wins over the stored status.
  assign status_now = rx_wen ? rx_data[STATUS_W-1:0] : status_q;
  assign unused_rx  = ^rx_data[31:STATUS_W];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cfg_d    = cfg_q;
    status_d = status_q;
    poll_d   = poll_q;
    start_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          op_d   = req_op_e'(req_op);
          addr_d = req_addr;
          len_d  = req_len;
          if (req_op_e'(req_op) == REQ_RSVD) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_WREN_ISSUE;
          end
        end
      end
      S_WREN_ISSUE: state_d = S_WREN_WAIT;
      S_WREN_WAIT: begin
        if (fsm_done) begin
`ifdef QSPI_SEQ_WEL_CHECK_EN
          state_d = S_WEL_ISSUE;
`else
          state_d = S_OP_ISSUE;
`endif
        end
      end
      S_WEL_ISSUE: begin
        status_d = 8'hFF;
        state_d  = S_WEL_WAIT;
      end
      S_WEL_WAIT: begin
        if (rx_wen) status_d = rx_data[STATUS_W-1:0];
        if (fsm_done) begin
          if (status_now[1]) begin
            state_d = S_OP_ISSUE;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_OP_ISSUE: state_d = S_OP_WAIT;
      S_OP_WAIT:  if (fsm_done) state_d = S_POLL_ISSUE;
      S_POLL_ISSUE: begin
        status_d = 8'hFF;
        poll_d   = (poll_q == '1) ? poll_q : poll_q + POLL_W'(1);
        state_d  = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (rx_wen) status_d = rx_data[STATUS_W-1:0];
        if (fsm_done) begin
          if (!status_now[0]) begin
            state_d = S_DONE;
          end else if (poll_q >= POLL_MAX) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP:  if (gap_expired) state_d = S_POLL_ISSUE;
      S_DONE: begin
        state_d = S_IDLE;
        poll_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Config and start are registered on entry to an issue state and held through its wait.
    case (state_d)
      S_WREN_ISSUE: begin
        cfg_d   = '{opcode: OPC_WREN, addr: 32'd0, len: 32'd0, addr_sel: ABS_NONE, dir: 1'b1};
        start_d = 1'b1;
      end
      S_WEL_ISSUE, S_POLL_ISSUE: begin
        cfg_d   = CFG_RDSR;
        start_d = 1'b1;
      end
      S_OP_ISSUE: begin
        cfg_d.opcode   = op_opcode(op_d);
        cfg_d.addr     = (op_d == REQ_CE) ? 32'd0 : addr_d;
        cfg_d.len      = (op_d == REQ_PP) ? len_d : 32'd0;
        cfg_d.addr_sel = (op_d == REQ_CE) ? ABS_NONE : ADDR_SEL;
        cfg_d.dir      = 1'b1;
        start_d        = 1'b1;
      end
      default: ;
    endcase

    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  assign gap_load = (state_q == S_POLL_WAIT) && (state_d == S_GAP);

  qspi_seq_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (POLL_GAP),
    .en_i       (state_q == S_GAP),
    .expired_o  (gap_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= REQ_PP;
      addr_q   <= '0;
      len_q    <= '0;
      cfg_q    <= '0;
      start_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      status_q <= 8'hFF;
      poll_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cfg_q    <= cfg_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
      poll_q   <= poll_d;
    end
  end

  assign req_ready          = ready_q;
  assign seq_done           = done_q;
  assign seq_err            = err_q;
  assign fsm_start          = start_q;
  assign fsm_cmd_opcode     = cfg_q.opcode;
  assign fsm_addr           = cfg_q.addr;
  assign fsm_len_bytes      = cfg_q.len;
  assign fsm_addr_bytes_sel = cfg_q.addr_sel;
  assign fsm_dir            = cfg_q.dir;
  assign fsm_cmd_lanes_sel  = 2'b00;
  assign fsm_addr_lanes_sel = 2'b00;
  assign fsm_data_lanes_sel = 2'b00;
  assign fsm_mode_en        = 1'b0;
  assign fsm_dummy_cycles   = 4'd0;

endmodule

// File: tb/tb_qspi_prog_sequencer.sv
// Scoreboard bench: a transaction-level flash model answers qspi_fsm starts; a reference
// model predicts every fsm_start configuration and the final seq_err of each request.
module tb_qspi_prog_sequencer;

  localparam logic [15:0] P_POLL_MAX = 16'd4;
  localparam logic [7:0]  P_POLL_GAP = 8'd3;
  localparam logic        P_ADDR4    = 1'b0;
  localparam int          NPOLL      = 4;

  typedef struct packed {
    logic [7:0]  opc;
    logic [31:0] addr;
    logic [31:0] len;
    logic [1:0]  asel;
    logic        dir;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_len;
  logic        seq_done, seq_err, fsm_start, fsm_done;
  logic [7:0]  fsm_cmd_opcode;
  logic [31:0] fsm_addr, fsm_len_bytes;
  logic [1:0]  fsm_addr_bytes_sel;
  logic        fsm_dir;
  logic [1:0]  fsm_cmd_lanes_sel, fsm_addr_lanes_sel, fsm_data_lanes_sel;
  logic        fsm_mode_en;
  logic [3:0]  fsm_dummy_cycles;
  logic [31:0] rx_data;
  logic        rx_wen;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;

  txn_t       exp_tx[$];
  logic       exp_done[$];
  logic [8:0] rsp_st[$];   // status bytes the flash model returns per RDSR; bit 8 = byte dropped
  logic [8:0] plan[$];     // poll statuses for the next request

  int         r_cyc, r_last_done, r_cnt, r_mode;
  logic       r_busy, r_rdsr, r_drop, r_prev_rdsr, r_was_busy;
  logic [7:0] r_byte;
  txn_t       r_cfg;

  always #5 clk = ~clk;

  qspi_prog_sequencer #(
    .POLL_MAX (P_POLL_MAX),
    .POLL_GAP (P_POLL_GAP),
    .ADDR4    (P_ADDR4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .seq_done           (seq_done),
    .seq_err            (seq_err),
    .fsm_start          (fsm_start),
    .fsm_done           (fsm_done),
    .fsm_cmd_opcode     (fsm_cmd_opcode),
    .fsm_addr           (fsm_addr),
    .fsm_len_bytes      (fsm_len_bytes),
    .fsm_addr_bytes_sel (fsm_addr_bytes_sel),
    .fsm_dir            (fsm_dir),
    .fsm_cmd_lanes_sel  (fsm_cmd_lanes_sel),
    .fsm_addr_lanes_sel (fsm_addr_lanes_sel),
    .fsm_data_lanes_sel (fsm_data_lanes_sel),
    .fsm_mode_en        (fsm_mode_en),
    .fsm_dummy_cycles   (fsm_dummy_cycles),
    .rx_data            (rx_data),
    .rx_wen             (rx_wen)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] eff(input logic [8:0] s);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic txn_t cur_cfg();
    return '{opc: fsm_cmd_opcode, addr: fsm_addr, len: fsm_len_bytes,
             asel: fsm_addr_bytes_sel, dir: fsm_dir};
  endfunction

  // Reference model: the flash command sequence a request must produce.
  task automatic build_expect(input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] len, input logic [8:0] wel);
    txn_t       rdsr, t;
    logic       err;
    logic [8:0] s;
    logic [7:0] b;
    rdsr = '{opc: 8'h05, addr: 32'd0, len: 32'd1, asel: 2'b00, dir: 1'b0};
    err  = (op == 2'b11);
    if (!err) begin
      exp_tx.push_back('{opc: 8'h06, addr: 32'd0, len: 32'd0, asel: 2'b00, dir: 1'b1});
`ifdef QSPI_SEQ_WEL_CHECK_EN
      exp_tx.push_back(rdsr);
      rsp_st.push_back(wel);
      b = eff(wel);
      if (!b[1]) err = 1'b1;
`else
      begin
        logic unused_wel;
        unused_wel = ^wel;
      end
`endif
      if (!err) begin
        t.opc  = (op == 2'b00) ? 8'h02 : (op == 2'b01) ? 8'h20 : 8'hC7;
        t.addr = (op == 2'b10) ? 32'd0 : addr;
        t.len  = (op == 2'b00) ? len : 32'd0;
        t.asel = (op == 2'b10) ? 2'b00 : (P_ADDR4 ? 2'b10 : 2'b01);
        t.dir  = 1'b1;
        exp_tx.push_back(t);
        for (int k = 1; k <= NPOLL; k++) begin
          s = (plan.size() > 0) ? plan.pop_front() : 9'h001;
          exp_tx.push_back(rdsr);
          rsp_st.push_back(s);
          b = eff(s);
          if (!b[0]) break;
          if (k == NPOLL) err = 1'b1;
        end
      end
    end
    plan.delete();
    exp_done.push_back(err);
  endtask

  task automatic flush();
    exp_tx.delete();
    exp_done.delete();
    rsp_st.delete();
    plan.delete();
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] len);
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
    req_op    = op;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = $urandom;
    chk("req_ready_busy", 128'(req_ready), 128'(1'b0));
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) begin
      compared++;
      mismatched++;
      $display("FAIL seq_done_timeout: no seq_done after %0d cycles", n);
      hard_reset();
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] len, input logic [8:0] wel);
    int base;
    base = done_cnt;
    build_expect(op, addr, len, wel);
    issue(op, addr, len);
    wait_done(base);
  endtask

  function automatic logic [8:0] busy_st();
    case ($urandom_range(0, 3))
      0:       return 9'h001;
      1:       return 9'h003;
      2:       return 9'h100;
      default: return {1'b0, 8'($urandom) | 8'h01};
    endcase
  endfunction

  // Behavioural qspi_fsm: done after 1..5 cycles, RDSR byte on time, early, after a decoy, or never.
  initial begin : flash_model
    fsm_done = 1'b0; rx_wen = 1'b0; rx_data = '0;
    r_busy = 1'b0; r_prev_rdsr = 1'b0; r_cyc = 0; r_last_done = 0;
    r_cnt = 0; r_mode = 0; r_rdsr = 1'b0; r_drop = 1'b0; r_byte = '0; r_cfg = '0;
    forever begin
      logic [8:0] s;
      @(posedge clk);
      #1;
      r_cyc++;
      fsm_done = 1'b0;
      rx_wen   = 1'b0;
      if (reset) begin
        r_busy      = 1'b0;
        r_prev_rdsr = 1'b0;
      end else begin
        r_was_busy = r_busy;
        if (r_busy) begin
          r_cnt--;
          if (r_rdsr && !r_drop) begin
            if ((r_cnt == 0 && r_mode != 1) || (r_cnt == 1 && r_mode == 1)) begin
              rx_wen = 1'b1; rx_data = {24'($urandom), r_byte};
            end else if (r_cnt == 1 && r_mode == 2) begin
              rx_wen = 1'b1; rx_data = {24'($urandom), r_byte ^ 8'h03};
            end
          end
          if (r_cnt == 0) begin
            chk("cfg_hold", 128'(cur_cfg()), 128'(r_cfg));
            fsm_done    = 1'b1;
            r_busy      = 1'b0;
            r_last_done = r_cyc;
            r_prev_rdsr = r_rdsr;
          end
        end
        if (fsm_start) begin
          chk("start_while_busy", 128'(r_was_busy), 128'(1'b0));
          if (fsm_cmd_opcode == 8'h05 && r_prev_rdsr)
            chk("poll_gap", 128'(r_cyc - r_last_done - 1), 128'(P_POLL_GAP));
          r_busy = 1'b1;
          r_cfg  = cur_cfg();
          r_cnt  = int'($urandom_range(1, 5));
          r_mode = (r_cnt >= 2) ? int'($urandom_range(0, 2)) : 0;
          r_rdsr = (fsm_cmd_opcode == 8'h05);
          r_drop = 1'b0;
          if (r_rdsr) begin
            s      = (rsp_st.size() > 0) ? rsp_st.pop_front() : 9'h001;
            r_drop = s[8];
            r_byte = s[7:0];
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops an expectation whenever the DUT starts a transaction or finishes.
  initial begin : monitor
    forever begin
      txn_t e;
      @(posedge clk);
      #1;
      if (!reset) begin
        if (fsm_start) begin
          if (exp_tx.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_start: opcode %0h with nothing expected", fsm_cmd_opcode);
          end else begin
            e = exp_tx.pop_front();
            chk("start_cfg", 128'(cur_cfg()), 128'(e));
          end
          chk("fixed_cfg", 128'({fsm_cmd_lanes_sel, fsm_addr_lanes_sel, fsm_data_lanes_sel,
                                 fsm_mode_en, fsm_dummy_cycles}), 128'(0));
        end
        if (seq_done) begin
          if (exp_done.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: seq_done with nothing expected");
          end else begin
            chk("seq_err", 128'(seq_err), 128'(exp_done.pop_front()));
          end
          chk("starts_left_at_done", 128'(exp_tx.size()), 128'(0));
          done_cnt++;
        end
      end
    end
  end

  initial begin : stimulus
    int base, n;
    logic [8:0] wel;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'(1'b1));
    chk("rst_outputs", 128'({fsm_start, seq_done, seq_err}), 128'(0));
    chk("rst_cfg", 128'(cur_cfg()), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 128'(req_ready), 128'(1'b1));

    plan = '{9'h003, 9'h003, 9'h000};
    do_req(2'b00, 32'h0000_1000, 32'd4, 9'h002);
    plan = '{9'h000};
    do_req(2'b01, 32'h0002_0000, 32'd77, 9'h002);
    plan = '{9'h001, 9'h000};
    do_req(2'b10, 32'h00AB_CDEF, 32'd9, 9'h002);
    plan = '{9'h001, 9'h001, 9'h001, 9'h001};
    do_req(2'b00, 32'h0000_4000, 32'd16, 9'h002);
    do_req(2'b11, 32'h0000_5000, 32'd8, 9'h002);
    plan = '{9'h100, 9'h0FE};
    do_req(2'b00, 32'h0000_6000, 32'd0, 9'h002);
`ifdef QSPI_SEQ_WEL_CHECK_EN
    plan = '{9'h000};
    do_req(2'b01, 32'h0007_0000, 32'd0, 9'h000);
    plan = '{9'h000};
    do_req(2'b01, 32'h0007_0000, 32'd0, 9'h002);
`endif

    // Reset while a status poll is outstanding, then a clean request.
    plan = '{9'h001, 9'h001, 9'h001, 9'h001};
    base = done_cnt;
    build_expect(2'b00, 32'h0000_8000, 32'd8, 9'h002);
    issue(2'b00, 32'h0000_8000, 32'd8);
    n = 0;
    while (!(r_busy && fsm_cmd_opcode == 8'h05 && rsp_st.size() < NPOLL) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reached_poll_wait", 128'(r_busy && fsm_cmd_opcode == 8'h05), 128'(1'b1));
    reset = 1'b1;
    flush();
    @(negedge clk);
    chk("midrst_ready", 128'(req_ready), 128'(1'b1));
    chk("midrst_start", 128'(fsm_start), 128'(1'b0));
    chk("midrst_no_done", 128'(done_cnt - base), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    plan = '{9'h001, 9'h000};
    do_req(2'b00, 32'h0000_9000, 32'd32, 9'h002);

    for (int t = 0; t < 40; t++) begin
      logic [1:0]  op;
      logic [31:0] len;
      int          np;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        repeat (NPOLL) plan.push_back(busy_st());
      end else begin
        np = int'($urandom_range(1, NPOLL));
        repeat (np - 1) plan.push_back(busy_st());
        plan.push_back({1'b0, 8'($urandom) & 8'hFE});
      end
      wel = ($urandom_range(0, 4) == 0) ? {1'b0, 8'($urandom) & 8'hFD}
                                        : {1'b0, 8'($urandom) | 8'h02};
      len = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 256));
      do_req(op, $urandom, len, wel);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
